// File: rtl/hxm_hit_feeder_pkg.sv
// Shared widths and FSM state encoding for the hxmpp hit feeder.
package hxm_hit_feeder_pkg;
  localparam int ROWINDEXBITS_HNM = 4;
  localparam int COLINDEXBITS_HNM = 4;
  localparam int SSIDBITS         = ROWINDEXBITS_HNM + COLINDEXBITS_HNM;
  localparam int HITINFOBITS      = 8;
  localparam int ENTRYBITS        = SSIDBITS + HITINFOBITS;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hxm_state_e;
endpackage

// File: rtl/hxm_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; count, full and empty derive from the pointer difference.
module hxm_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PTR_DEPTH);
  assign empty = (count == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    else      wr_ptr_d = wr_ptr_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    else      rd_ptr_d = rd_ptr_q;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/hxm_hit_feeder.sv
// Upstream hit feeder for hxmpp: buffers hits, issues one write per clock, flags event completion.
// Optional HXM_HIT_COUNT_EN adds hit_count and fifo_overflow_seen.
module hxm_hit_feeder
  import hxm_hit_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int INIT_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROWINDEXBITS_HNM-1:0] in_row,
  input  logic [COLINDEXBITS_HNM-1:0] in_col,
  input  logic [HITINFOBITS-1:0]      in_hitInfo,
  input  logic                        event_end,
  output logic                        write,
  output logic [SSIDBITS-1:0]         writeSSID,
  output logic [HITINFOBITS-1:0]      writeHitInfo,
  output logic                        event_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef HXM_HIT_COUNT_EN
  ,
  output logic [15:0]                 hit_count,
  output logic                        fifo_overflow_seen
`endif
);
  localparam int HW = $clog2(INIT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(INIT_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  hxm_state_e             state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   write_q, write_d;
  logic [SSIDBITS-1:0]    ssid_q, ssid_d;
  logic [HITINFOBITS-1:0] info_q, info_d;
  logic                   done_q, done_d;

  logic                   push_s, pop_s, full_s, empty_s;
  logic [ENTRYBITS-1:0]   rdata_s;
  logic [$clog2(FIFO_DEPTH):0] count_s;

  assign in_ready     = (state_q == RUN) && !full_s;
  assign push_s       = in_valid && in_ready;
  assign pop_s        = ((state_q == RUN) || (state_q == DRAIN)) && !empty_s;
  assign write        = write_q;
  assign writeSSID    = ssid_q;
  assign writeHitInfo = info_q;
  assign event_done   = done_q;
  assign fifo_count   = count_s;

  hxm_sync_fifo #(.WIDTH(ENTRYBITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({in_row, in_col, in_hitInfo}),
    .rdata (rdata_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Phase sequencing: hold-off after reset, then run/drain/done per event
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      INIT: begin
        if (hold_q <= HOLD_ONE) begin
          hold_d  = '0;
          state_d = RUN;
        end else begin
          hold_d  = hold_q - HOLD_ONE;
          state_d = INIT;
        end
      end
      RUN:     if (event_end) state_d = DRAIN; else state_d = RUN;
      DRAIN:   if (empty_s)   state_d = DONE;  else state_d = DRAIN;
      DONE:    state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Next values of the write port; data holds on idle cycles
  always_comb begin
    write_d = pop_s;
    done_d  = (state_q == DRAIN) && empty_s;
    if (pop_s) begin
      ssid_d = rdata_s[ENTRYBITS-1:HITINFOBITS];
      info_d = rdata_s[HITINFOBITS-1:0];
    end else begin
      ssid_d = ssid_q;
      info_d = info_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      hold_q  <= HOLD_INIT;
      write_q <= 1'b0;
      ssid_q  <= '0;
      info_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      write_q <= write_d;
      ssid_q  <= ssid_d;
      info_q  <= info_d;
      done_q  <= done_d;
    end
  end

`ifdef HXM_HIT_COUNT_EN
  localparam int OW = $clog2(FIFO_DEPTH + 2);
  localparam logic [OW-1:0] OVF_LIMIT = OW'(FIFO_DEPTH);

  logic [15:0]   hit_count_q, hit_count_d;
  logic [OW-1:0] ovf_cnt_q, ovf_cnt_d;
  logic          ovf_seen_q, ovf_seen_d;

  assign hit_count          = hit_count_q;
  assign fifo_overflow_seen = ovf_seen_q;

  // Per-event write tally and stalled-while-full detector (counter saturates past the limit)
  always_comb begin
    if (done_q)                                     hit_count_d = 16'd0;
    else if (write_q && (hit_count_q != 16'hFFFF)) hit_count_d = hit_count_q + 16'd1;
    else                                            hit_count_d = hit_count_q;
    if (in_valid && full_s) begin
      if (ovf_cnt_q > OVF_LIMIT) ovf_cnt_d = ovf_cnt_q;
      else                       ovf_cnt_d = ovf_cnt_q + OW'(1);
    end else begin
      ovf_cnt_d = '0;
    end
    ovf_seen_d = ovf_seen_q || (ovf_cnt_d > OVF_LIMIT);
  end

  // Optional statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q <= 16'd0;
      ovf_cnt_q   <= '0;
      ovf_seen_q  <= 1'b0;
    end else begin
      hit_count_q <= hit_count_d;
      ovf_cnt_q   <= ovf_cnt_d;
      ovf_seen_q  <= ovf_seen_d;
    end
  end
`endif
endmodule

// File: tb/tb_hxm_hit_feeder.sv
// Self-checking bench for hxm_hit_feeder: a cycle-stamped scoreboard predicts every write and event_done.
module tb_hxm_hit_feeder;
  typedef struct {
    int         cyc;
    logic [7:0] ssid;
    logic [7:0] info;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_row = 4'd0;
  logic [3:0] in_col = 4'd0;
  logic [7:0] in_hitInfo = 8'd0;
  logic       event_end = 1'b0;
  logic       write;
  logic [7:0] writeSSID;
  logic [7:0] writeHitInfo;
  logic       event_done;
  logic [4:0] fifo_count;
`ifdef HXM_HIT_COUNT_EN
  logic [15:0] hit_count;
  logic        fifo_overflow_seen;
  bit          chk_zero = 1'b0;
`endif

  int  checks = 0, errors = 0, cyc = 0;
  int  n_writes = 0, n_dones = 0, ev_writes = 0;
  int  run_start = 1000000, close_end = -1, last_wr = -100;
  bit  prev_acc = 1'b0;
  wr_t exp_q[$];
  int  exp_done[$];
  wr_t mon_e;
  int  mon_d;

  hxm_hit_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col), .in_hitInfo(in_hitInfo), .event_end(event_end),
    .write(write), .writeSSID(writeSSID), .writeHitInfo(writeHitInfo),
    .event_done(event_done), .fifo_count(fifo_count)
`ifdef HXM_HIT_COUNT_EN
    , .hit_count(hit_count), .fifo_overflow_seen(fifo_overflow_seen)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write and event_done must match a predicted entry, in order and on its cycle
  always @(negedge clk) begin
`ifdef HXM_HIT_COUNT_EN
    if (chk_zero) begin
      chk_zero = 1'b0;
      checks++;
      if (hit_count !== 16'd0) begin
        errors++;
        $display("FAIL hit_count_clear: cycle %0d got %0d required 0", cyc, hit_count);
      end
    end
`endif
    if (write === 1'b1) begin
      n_writes++;
      ev_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: cycle %0d ssid=%h info=%h, required no write", cyc, writeSSID, writeHitInfo);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.cyc || writeSSID !== mon_e.ssid || writeHitInfo !== mon_e.info) begin
          errors++;
          $display("FAIL write: got cyc=%0d ssid=%h info=%h, required cyc=%0d ssid=%h info=%h",
                   cyc, writeSSID, writeHitInfo, mon_e.cyc, mon_e.ssid, mon_e.info);
        end
      end
    end
    if (event_done === 1'b1) begin
      n_dones++;
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event_done: cycle %0d, required none", cyc);
      end else begin
        mon_d = exp_done.pop_front();
        if (cyc !== mon_d) begin
          errors++;
          $display("FAIL event_done_cycle: got %0d required %0d", cyc, mon_d);
        end
      end
`ifdef HXM_HIT_COUNT_EN
      checks++;
      if (hit_count !== 16'(ev_writes)) begin
        errors++;
        $display("FAIL hit_count: got %0d required %0d", hit_count, ev_writes);
      end
      chk_zero = 1'b1;
`endif
      ev_writes = 0;
    end
  end

  // One clock of stimulus; the model predicts readiness, occupancy and the resulting writes
  task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] c,
                       input logic [7:0] info, input logic e);
    bit rdy;
    in_valid = v; in_row = r; in_col = c; in_hitInfo = info; event_end = e;
    rdy = (cyc >= run_start) && (cyc > close_end);
    checks += 2;
    if (in_ready !== rdy) begin
      errors++;
      $display("FAIL in_ready: cycle %0d got %b required %b", cyc, in_ready, rdy);
    end
    if (fifo_count !== {4'd0, prev_acc}) begin
      errors++;
      $display("FAIL fifo_count: cycle %0d got %0d required %0d", cyc, fifo_count, prev_acc);
    end
    prev_acc = v && rdy;
    if (v && rdy) begin
      exp_q.push_back('{cyc + 2, {r, c}, info});
      last_wr = cyc + 2;
    end
    if (e && rdy) begin
      close_end = (cyc + 2 > last_wr + 1) ? cyc + 2 : last_wr + 1;
      exp_done.push_back(close_end);
    end
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    run_start = cyc + 8;
    close_end = -1;
    last_wr = -100;
    prev_acc = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int wrs;
    reset = 1'b1;
    @(posedge clk); #1;
    checks += 6;
    if (write !== 1'b0)        begin errors++; $display("FAIL rst_write: got %b required 0", write); end
    if (writeSSID !== 8'd0)    begin errors++; $display("FAIL rst_ssid: got %h required 00", writeSSID); end
    if (writeHitInfo !== 8'd0) begin errors++; $display("FAIL rst_info: got %h required 00", writeHitInfo); end
    if (event_done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b required 0", event_done); end
    if (in_ready !== 1'b0)     begin errors++; $display("FAIL rst_ready: got %b required 0", in_ready); end
    if (fifo_count !== 5'd0)   begin errors++; $display("FAIL rst_count: got %0d required 0", fifo_count); end
    @(posedge clk); #1;
    release_reset();
    wrs = n_writes;
    n = 0;
    while (n < 20 && in_ready !== 1'b1) begin
      drive(1'b1, 4'($urandom), 4'($urandom), 8'($urandom), 1'b0);
      n++;
    end
    checks += 2;
    if (n !== 8) begin errors++; $display("FAIL holdoff_len: got %0d cycles required 8", n); end
    if (n_writes !== wrs) begin errors++; $display("FAIL init_write: got %0d writes required 0", n_writes - wrs); end
    drive(1'b1, 4'($urandom), 4'($urandom), 8'($urandom), 1'b0);
    repeat (3) drive(1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic test_single();
    int wrs;
    wrs = n_writes;
    drive(1'b1, 4'd8, 4'd8, 8'h88, 1'b0);
    repeat (4) drive(1'b0, 4'd1, 4'd2, 8'h33, 1'b0);
    checks += 4;
    if (n_writes !== wrs + 1)   begin errors++; $display("FAIL single_count: got %0d required 1", n_writes - wrs); end
    if (writeSSID !== 8'h88)    begin errors++; $display("FAIL single_ssid_hold: got %h required 88", writeSSID); end
    if (writeHitInfo !== 8'h88) begin errors++; $display("FAIL single_info_hold: got %h required 88", writeHitInfo); end
    if (write !== 1'b0)         begin errors++; $display("FAIL single_write_idle: got %b required 0", write); end
  endtask

  task automatic test_burst_event();
    int rows[23] = '{8,8,8,8,8,8,8,8,2,9,4,12,3,3,8,4,4,4,4,4,4,4,4};
    int wrs;
    int dns;
    wrs = n_writes;
    dns = n_dones;
    for (int i = 0; i < 23; i++)
      drive(1'b1, 4'(rows[i]), 4'(rows[i]), 8'($urandom), (i == 22) ? 1'b1 : 1'b0);
    repeat (6) drive(1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
    checks += 3;
    if (n_writes !== wrs + 23) begin errors++; $display("FAIL burst_writes: got %0d required 23", n_writes - wrs); end
    if (n_dones !== dns + 1)   begin errors++; $display("FAIL burst_done_count: got %0d required 1", n_dones - dns); end
    if (exp_done.size() !== 0) begin errors++; $display("FAIL burst_done_pending: got %0d required 0", exp_done.size()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 4'($urandom), 4'($urandom), 8'($urandom),
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    repeat (6) drive(1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int wrs;
    for (int i = 0; i < 10; i++)
      drive(1'b1, 4'($urandom), 4'($urandom), 8'($urandom), (i == 9) ? 1'b1 : 1'b0);
    reset = 1'b1;
    #1;
    checks += 5;
    if (write !== 1'b0)        begin errors++; $display("FAIL mid_write: got %b required 0", write); end
    if (writeSSID !== 8'd0)    begin errors++; $display("FAIL mid_ssid: got %h required 00", writeSSID); end
    if (writeHitInfo !== 8'd0) begin errors++; $display("FAIL mid_info: got %h required 00", writeHitInfo); end
    if (in_ready !== 1'b0)     begin errors++; $display("FAIL mid_ready: got %b required 0", in_ready); end
    if (fifo_count !== 5'd0)   begin errors++; $display("FAIL mid_count: got %0d required 0", fifo_count); end
    exp_q.delete();
    exp_done.delete();
    ev_writes = 0;
    @(posedge clk); #1;
    release_reset();
    wrs = n_writes;
    repeat (8) drive(1'b1, 4'($urandom), 4'($urandom), 8'($urandom), 1'b1);
    checks++;
    if (n_writes !== wrs) begin errors++; $display("FAIL mid_no_write: got %0d writes required 0", n_writes - wrs); end
    repeat (5) drive(1'b1, 4'($urandom), 4'($urandom), 8'($urandom), 1'b0);
    drive(1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
    repeat (6) drive(1'b0, 4'd0, 4'd0, 8'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_event();
    test_random();
    test_reset_mid();
    checks += 2;
    if (exp_q.size() !== 0)    begin errors++; $display("FAIL missing_writes: got %0d pending required 0", exp_q.size()); end
    if (exp_done.size() !== 0) begin errors++; $display("FAIL missing_done: got %0d pending required 0", exp_done.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
